// File: rtl/snake_mover_pkg.sv
// Shared types, sizes and helpers for the snake game-logic stage.
package snake_mover_pkg;

    localparam int unsigned GRID_W      = 40;
    localparam int unsigned GRID_H      = 30;
    localparam int unsigned MAX_LEN     = 64;
    localparam int unsigned START_LEN   = 4;
    localparam int unsigned STEP_FRAMES = 8;

    localparam int unsigned X_W     = $clog2(GRID_W);
    localparam int unsigned Y_W     = $clog2(GRID_H);
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned PTR_W   = $clog2(MAX_LEN);
    localparam int unsigned CNT_W   = $clog2(STEP_FRAMES + 1);
    localparam int unsigned COLOR_W = 16;

    localparam logic [COLOR_W-1:0] HEAD_COLOR = 16'h03E0;
    localparam logic [COLOR_W-1:0] BG_COLOR   = 16'h0000;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } cell_t;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_CALC, S_CHECK, S_ERASE, S_DRAW, S_DEAD
    } state_e;

    // Encoding places each direction opposite its mirror index.
    function automatic dir_e opposite(input dir_e d);
        return dir_e'(2'(2'd3 - 2'(d)));
    endfunction

    // Lowest-index key wins; a reversal onto the last direction is refused.
    function automatic dir_e pick_dir(input logic [3:0] mov, input dir_e cur);
        dir_e req;
        if (mov[0])      req = DIR_RIGHT;
        else if (mov[1]) req = DIR_DOWN;
        else if (mov[2]) req = DIR_UP;
        else if (mov[3]) req = DIR_LEFT;
        else             req = cur;
        return (req == opposite(cur)) ? cur : req;
    endfunction

    // One cell in direction d with toroidal wrap, computed one bit wider.
    function automatic cell_t step_cell(input cell_t c, input dir_e d);
        logic [X_W:0] nx;
        logic [Y_W:0] ny;
        cell_t        res;
        nx = {1'b0, c.x};
        ny = {1'b0, c.y};
        case (d)
            DIR_RIGHT: nx = (nx == (X_W+1)'(GRID_W - 1)) ? '0 : nx + 1'b1;
            DIR_LEFT:  nx = (nx == '0) ? (X_W+1)'(GRID_W - 1) : nx - 1'b1;
            DIR_DOWN:  ny = (ny == (Y_W+1)'(GRID_H - 1)) ? '0 : ny + 1'b1;
            DIR_UP:    ny = (ny == '0) ? (Y_W+1)'(GRID_H - 1) : ny - 1'b1;
            default:   ;
        endcase
        res.x = X_W'(nx);
        res.y = Y_W'(ny);
        return res;
    endfunction

    // Segment i of the starting body, counted from the tail.
    function automatic cell_t start_cell(input int unsigned i);
        int unsigned x;
        cell_t       res;
        x     = (GRID_W / 2 + GRID_W * MAX_LEN - (START_LEN - 1) + i) % GRID_W;
        res.x = X_W'(x);
        res.y = Y_W'(GRID_H / 2);
        return res;
    endfunction

endpackage

// File: rtl/snake_mover_if.sv
// Cell write-command channel towards the framebuffer drawer.
interface snake_mover_if;
    import snake_mover_pkg::*;

    logic               wr_req;
    logic               wr_ack;
    logic [X_W-1:0]     wr_x;
    logic [Y_W-1:0]     wr_y;
    logic [COLOR_W-1:0] wr_color;

    modport master (output wr_req, output wr_x, output wr_y, output wr_color, input wr_ack);
    modport slave  (input wr_req, input wr_x, input wr_y, input wr_color, output wr_ack);
endinterface

// File: rtl/snake_mover_ring.sv
// Circular segment buffer: tail-relative random read, push at head, pop at tail.
module snake_ring
    import snake_mover_pkg::*;
(
    input  logic             clk,
    input  logic             rst_i,
    input  logic             push_i,
    input  cell_t            push_cell_i,
    input  logic             pop_i,
    input  logic [LEN_W-1:0] rd_off_i,
    output cell_t            rd_cell_o,
    output cell_t            head_cell_o,
    output cell_t            tail_cell_o
);

    cell_t            mem_q [MAX_LEN];
    logic [PTR_W-1:0] head_ptr_q;
    logic [PTR_W-1:0] tail_ptr_q;
    logic [LEN_W:0]   rd_sum_c;
    logic [PTR_W-1:0] rd_ptr_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    // Offset from tail folded back into the ring.
    always_comb begin
        rd_sum_c = (LEN_W+1)'(tail_ptr_q) + (LEN_W+1)'(rd_off_i);
        if (rd_sum_c >= (LEN_W+1)'(MAX_LEN)) begin
            rd_sum_c = rd_sum_c - (LEN_W+1)'(MAX_LEN);
        end
        rd_ptr_c = PTR_W'(rd_sum_c);
    end

    assign rd_cell_o   = mem_q[rd_ptr_c];
    assign head_cell_o = mem_q[head_ptr_q];
    assign tail_cell_o = mem_q[tail_ptr_q];

    // Reset loads the starting body; otherwise push/pop move the pointers.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            tail_ptr_q <= '0;
            head_ptr_q <= PTR_W'(START_LEN - 1);
            for (int unsigned i = 0; i < START_LEN; i++) begin
                mem_q[PTR_W'(i)] <= start_cell(i);
            end
        end else begin
            if (push_i) begin
                mem_q[ptr_inc(head_ptr_q)] <= push_cell_i;
                head_ptr_q                 <= ptr_inc(head_ptr_q);
            end
            if (pop_i) begin
                tail_ptr_q <= ptr_inc(tail_ptr_q);
            end
        end
    end

endmodule

// File: rtl/snake_mover.sv
// Snake game logic: step timing, direction latch, collision scan, cell write commands.
module snake_mover
    import snake_mover_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_snake_i,
    input  logic             frame_sync_i,
    input  logic [3:0]       mov_i,
    input  logic             grow_i,
    snake_mover_if.master    wr_if,
    output logic             dead_o,
    output logic [LEN_W-1:0] length_o,
    output logic             busy_o
);

    logic               reset_c;
    logic               fs_meta_q, fs_sync_q, fs_prev_q;
    logic               frame_rise_c, step_wrap_c;
    logic [CNT_W-1:0]   frame_cnt_q;
    logic               step_pending_q, grow_pending_q;
    logic               step_take_c, grow_take_c, push_c, pop_c, xfer_c;

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    cell_t              next_head_q, next_head_d;
    logic               growing_q, growing_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   length_q, length_d;
    logic               wr_req_q, wr_req_d;
    cell_t              wr_cell_q, wr_cell_d;
    logic [COLOR_W-1:0] wr_color_q, wr_color_d;
    logic               dead_q, busy_q;

    cell_t              rd_cell_c, head_cell_c, tail_cell_c;

    assign reset_c      = rst | rst_snake_i;
    assign frame_rise_c = fs_sync_q & ~fs_prev_q;
    assign step_wrap_c  = frame_rise_c && (frame_cnt_q == CNT_W'(STEP_FRAMES - 1));
    assign xfer_c       = wr_req_q & wr_if.wr_ack;

    snake_ring u_ring (
        .clk         (clk),
        .rst_i       (reset_c),
        .push_i      (push_c),
        .push_cell_i (next_head_q),
        .pop_i       (pop_c),
        .rd_off_i    (idx_q),
        .rd_cell_o   (rd_cell_c),
        .head_cell_o (head_cell_c),
        .tail_cell_o (tail_cell_c)
    );

    // Frame sync synchroniser, step divider and the one-deep step/grow holds.
    always_ff @(posedge clk) begin
        if (reset_c) begin
            fs_meta_q      <= 1'b0;
            fs_sync_q      <= 1'b0;
            fs_prev_q      <= 1'b0;
            frame_cnt_q    <= '0;
            step_pending_q <= 1'b0;
            grow_pending_q <= 1'b0;
        end else begin
            fs_meta_q <= frame_sync_i;
            fs_sync_q <= fs_meta_q;
            fs_prev_q <= fs_sync_q;
            if (frame_rise_c) begin
                frame_cnt_q <= step_wrap_c ? '0 : frame_cnt_q + 1'b1;
            end
            if (step_wrap_c)      step_pending_q <= 1'b1;
            else if (step_take_c) step_pending_q <= 1'b0;
            if (grow_i)           grow_pending_q <= 1'b1;
            else if (grow_take_c) grow_pending_q <= 1'b0;
        end
    end

    // Next-state and command generation.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        next_head_d = next_head_q;
        growing_d   = growing_q;
        idx_d       = idx_q;
        length_d    = length_q;
        wr_req_d    = wr_req_q;
        wr_cell_d   = wr_cell_q;
        wr_color_d  = wr_color_q;
        step_take_c = 1'b0;
        grow_take_c = 1'b0;
        push_c      = 1'b0;
        pop_c       = 1'b0;

        case (state_q)
            S_INIT: begin
                if (!wr_req_q || xfer_c) begin
                    if (idx_q == LEN_W'(START_LEN)) begin
                        wr_req_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        wr_req_d   = 1'b1;
                        wr_cell_d  = rd_cell_c;
                        wr_color_d = HEAD_COLOR;
                        idx_d      = idx_q + 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (step_pending_q) begin
                    step_take_c = 1'b1;
                    state_d     = S_CALC;
                end
            end
            S_CALC: begin
                dir_d       = pick_dir(mov_i, dir_q);
                next_head_d = step_cell(head_cell_c, dir_d);
                growing_d   = grow_pending_q && (length_q < LEN_W'(MAX_LEN));
                grow_take_c = 1'b1;
                idx_d       = growing_d ? '0 : LEN_W'(1);
                state_d     = S_CHECK;
            end
            S_CHECK: begin
                if (rd_cell_c == next_head_q) begin
                    state_d = S_DEAD;
                end else if (idx_q == length_q - 1'b1) begin
                    wr_req_d = 1'b1;
                    if (growing_q) begin
                        wr_cell_d  = next_head_q;
                        wr_color_d = HEAD_COLOR;
                        state_d    = S_DRAW;
                    end else begin
                        wr_cell_d  = tail_cell_c;
                        wr_color_d = BG_COLOR;
                        state_d    = S_ERASE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_ERASE: begin
                if (xfer_c) begin
                    pop_c      = 1'b1;
                    wr_req_d   = 1'b1;
                    wr_cell_d  = next_head_q;
                    wr_color_d = HEAD_COLOR;
                    state_d    = S_DRAW;
                end
            end
            S_DRAW: begin
                if (xfer_c) begin
                    push_c   = 1'b1;
                    wr_req_d = 1'b0;
                    if (growing_q) length_d = length_q + 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_DEAD: begin
                wr_req_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset_c) begin
            state_q     <= S_INIT;
            dir_q       <= DIR_RIGHT;
            next_head_q <= '0;
            growing_q   <= 1'b0;
            idx_q       <= '0;
            length_q    <= LEN_W'(START_LEN);
            wr_req_q    <= 1'b0;
            wr_cell_q   <= '0;
            wr_color_q  <= '0;
            dead_q      <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            next_head_q <= next_head_d;
            growing_q   <= growing_d;
            idx_q       <= idx_d;
            length_q    <= length_d;
            wr_req_q    <= wr_req_d;
            wr_cell_q   <= wr_cell_d;
            wr_color_q  <= wr_color_d;
            dead_q      <= (state_d == S_DEAD);
            busy_q      <= !((state_d == S_IDLE) || (state_d == S_DEAD));
        end
    end

    assign wr_if.wr_req   = wr_req_q;
    assign wr_if.wr_x     = wr_cell_q.x;
    assign wr_if.wr_y     = wr_cell_q.y;
    assign wr_if.wr_color = wr_color_q;
    assign dead_o         = dead_q;
    assign length_o       = length_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_snake_mover.sv
// Randomised bench for snake_mover against a queue-based game model.
module tb_snake_mover;
    import snake_mover_pkg::*;

    logic             clk = 1'b0;
    logic             rst, rst_snake, frame_sync, grow;
    logic [3:0]       mov;
    logic             dead, busy;
    logic [LEN_W-1:0] length;

    snake_mover_if wr_if ();

    snake_mover dut (
        .clk          (clk),
        .rst          (rst),
        .rst_snake_i  (rst_snake),
        .frame_sync_i (frame_sync),
        .mov_i        (mov),
        .grow_i       (grow),
        .wr_if        (wr_if),
        .dead_o       (dead),
        .length_o     (length),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_pct  = 100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_cmd(input int x, input int y, input logic [15:0] c);
        return (32'(x) << 24) | (32'(y) << 16) | 32'(c);
    endfunction

    // Downstream acceptance, changed just after each active edge.
    always @(posedge clk) begin
        #1;
        wr_if.wr_ack = ($urandom_range(99) < ack_pct);
    end

    // Command capture and hold-while-stalled checks, sampled mid-cycle.
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    logic        p_req = 1'b0, p_ack = 1'b0, p_rst = 1'b1;
    logic [31:0] p_pay = '0;

    always @(negedge clk) begin
        logic [31:0] cur;
        cur = pack_cmd(int'(wr_if.wr_x), int'(wr_if.wr_y), wr_if.wr_color);
        if (p_req && !p_ack && !p_rst) begin
            check("hold_req", wr_if.wr_req, 1);
            check("hold_payload", cur, p_pay);
        end
        if (wr_if.wr_req === 1'b1 && wr_if.wr_ack === 1'b1 && !rst && !rst_snake)
            obs_q.push_back(cur);
        p_req = (wr_if.wr_req === 1'b1);
        p_ack = (wr_if.wr_ack === 1'b1);
        p_pay = cur;
        p_rst = rst | rst_snake;
    end

    // Game model: body as coordinate queues, tail at index 0.
    int mx[$], my[$];
    int m_dir, m_len;
    bit m_grow, m_dead;
    int dx_t[4]  = '{1, 0, 0, -1};
    int dy_t[4]  = '{0, 1, -1, 0};
    int opp_t[4] = '{3, 2, 1, 0};

    function automatic void model_reset();
        mx.delete(); my.delete(); exp_q.delete(); obs_q.delete();
        for (int i = 0; i < int'(START_LEN); i++) begin
            mx.push_back(int'(GRID_W) / 2 - (int'(START_LEN) - 1) + i);
            my.push_back(int'(GRID_H) / 2);
            exp_q.push_back(pack_cmd(mx[i], my[i], 16'h03E0));
        end
        m_dir = 0; m_len = int'(START_LEN); m_grow = 0; m_dead = 0;
    endfunction

    function automatic void model_step(input logic [3:0] mv);
        int  req, nx, ny, first;
        bit  growing;
        if (m_dead) return;
        req = -1;
        for (int i = 3; i >= 0; i--) if (mv[i]) req = i;
        if (req >= 0 && req != opp_t[m_dir]) m_dir = req;
        nx = (mx[mx.size()-1] + dx_t[m_dir] + int'(GRID_W)) % int'(GRID_W);
        ny = (my[my.size()-1] + dy_t[m_dir] + int'(GRID_H)) % int'(GRID_H);
        growing = m_grow && (m_len < int'(MAX_LEN));
        m_grow = 0;
        first = growing ? 0 : 1;
        for (int i = first; i < mx.size(); i++) begin
            if (mx[i] == nx && my[i] == ny) begin
                m_dead = 1;
                return;
            end
        end
        if (!growing) begin
            exp_q.push_back(pack_cmd(mx[0], my[0], 16'h0000));
            void'(mx.pop_front());
            void'(my.pop_front());
        end else begin
            m_len++;
        end
        mx.push_back(nx);
        my.push_back(ny);
        exp_q.push_back(pack_cmd(nx, ny, 16'h03E0));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        frame_sync = 1'b1; tick(); tick();
        frame_sync = 1'b0; tick(); tick();
    endtask

    task automatic wait_idle();
        int n;
        repeat (4) tick();
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check("idle_wait", busy, 0);
    endtask

    task automatic compare_cmds(input string tag);
        int n;
        check({tag, "_ncmd"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_cmd"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
        check({tag, "_len"}, length, m_len);
        check({tag, "_dead"}, dead, m_dead);
    endtask

    task automatic apply_reset(input bit use_snake);
        if (use_snake) rst_snake = 1'b1; else rst = 1'b1;
        tick();
        rst = 1'b0; rst_snake = 1'b0;
        check("rst_req", wr_if.wr_req, 0);
        check("rst_busy", busy, 1);
        check("rst_len", length, START_LEN);
        check("rst_dead", dead, 0);
        model_reset();
    endtask

    task automatic init_phase(input bit use_snake);
        apply_reset(use_snake);
        wait_idle();
        compare_cmds("init");
    endtask

    task automatic do_step(input logic [3:0] mv, input bit g, input string tag);
        mov = mv;
        if (g) begin
            grow = 1'b1; tick(); grow = 1'b0;
            m_grow = 1;
        end
        model_step(mv);
        repeat (STEP_FRAMES) frame_pulse();
        wait_idle();
        compare_cmds(tag);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!wr_if.wr_req && n < 300) begin
            tick();
            n++;
        end
        check("req_wait", wr_if.wr_req, 1);
    endtask

    initial begin
        logic [31:0] held;
        logic [3:0]  mv;
        rst = 1'b1; rst_snake = 1'b0; frame_sync = 1'b0; mov = '0; grow = 1'b0;
        repeat (3) tick();

        // Reset body drawn tail to head, then one plain step.
        init_phase(0);
        do_step(4'b0000, 0, "step1");

        // Horizontal wrap at the right edge, then vertical wrap at the bottom.
        for (int i = 0; i < 19; i++) do_step(4'b0000, 0, "xwrap");
        for (int i = 0; i < 16; i++) do_step(4'b0010, 0, "ywrap");

        // Growth up to and beyond the buffer depth along a staircase.
        init_phase(1);
        for (int i = 0; i < 62; i++) do_step((i % 2 == 0) ? 4'b0001 : 4'b0010, 1, "grow");
        check("grow_sat", length, MAX_LEN);

        // Reversal refused, then a tight turn into the body.
        init_phase(0);
        do_step(4'b1000, 0, "noreverse");
        do_step(4'b0000, 1, "grow5");
        do_step(4'b0100, 0, "turn_up");
        do_step(4'b1000, 0, "turn_left");
        do_step(4'b0010, 0, "turn_down");
        check("dead_flag", dead, 1);
        do_step(4'b0000, 0, "after_dead");

        // Long stall with a second step tick arriving mid-stall.
        init_phase(0);
        ack_pct = 0;
        mov = 4'b0000;
        model_step(4'b0000);
        repeat (STEP_FRAMES) frame_pulse();
        wait_req();
        held = pack_cmd(int'(wr_if.wr_x), int'(wr_if.wr_y), wr_if.wr_color);
        repeat (20) tick();
        check("stall_req", wr_if.wr_req, 1);
        check("stall_payload", pack_cmd(int'(wr_if.wr_x), int'(wr_if.wr_y), wr_if.wr_color), held);
        model_step(4'b0000);
        repeat (STEP_FRAMES) frame_pulse();
        ack_pct = 100;
        wait_idle();
        repeat (20) tick();
        wait_idle();
        compare_cmds("stall_tick");

        // Reset while a command is stalled.
        ack_pct = 0;
        repeat (STEP_FRAMES) frame_pulse();
        wait_req();
        repeat (3) tick();
        ack_pct = 100;
        init_phase(0);

        // Random play with random back-pressure.
        for (int s = 0; s < 150; s++) begin
            if (m_dead) init_phase(1'($urandom_range(1)));
            ack_pct = int'($urandom_range(30, 100));
            case ($urandom_range(5))
                0:       mv = 4'b0000;
                1:       mv = 4'b0001;
                2:       mv = 4'b0010;
                3:       mv = 4'b0100;
                4:       mv = 4'b1000;
                default: mv = 4'($urandom);
            endcase
            do_step(mv, ($urandom_range(3) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
